// File: rtl/rob_pkg.sv
// Shared opcode constants, entry layout and pointer helpers for the reorder buffer.
package rob_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned OPW  = 7;

   localparam logic [OPW-1:0] OP_LUI   = 7'b0110111;
   localparam logic [OPW-1:0] OP_AUIPC = 7'b0010111;
   localparam logic [OPW-1:0] OP_JAL   = 7'b1101111;
   localparam logic [OPW-1:0] OP_JALR  = 7'b1100111;
   localparam logic [OPW-1:0] OP_BR    = 7'b1100011;
   localparam logic [OPW-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPW-1:0] OP_STORE = 7'b0100011;
   localparam logic [OPW-1:0] OP_OPIMM = 7'b0010011;
   localparam logic [OPW-1:0] OP_OP    = 7'b0110011;

   // One reorder-buffer slot; target is only meaningful for JALR.
   typedef struct packed {
      logic            busy;
      logic            done;
      logic [OPW-1:0]  op;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] value;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
   } rob_entry_t;

   // Result of an operand lookup.
   typedef struct packed {
      logic            pend;
      logic [XLEN-1:0] val;
   } lookup_t;

   // Opcodes that write the register file at commit.
   function automatic logic has_rd(input logic [OPW-1:0] op);
      case (op)
         OP_OP, OP_OPIMM, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Next ID in the 1..depth ring.
   function automatic int unsigned id_inc(input int unsigned id, input int unsigned depth);
      return (id >= depth) ? 32'd1 : id + 32'd1;
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Decides which commit lanes retire this cycle and whether the head redirects fetch.
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int unsigned COMMIT_W = 2
) (
   input  logic            head_busy,
   input  logic            head_done,
   input  logic [OPW-1:0]  head_op,
   input  logic [RW-1:0]   head_rd,
   input  logic [XLEN-1:0] head_pc,
   input  logic [XLEN-1:0] head_imm,
   input  logic [XLEN-1:0] head_target,
   input  logic            head_taken,
   input  logic            nxt_busy,
   input  logic            nxt_done,
   input  logic [OPW-1:0]  nxt_op,
   input  logic [RW-1:0]   nxt_rd,
   output logic            lane0_c,
   output logic            lane1_c,
   output logic            flush_c,
   output logic [XLEN-1:0] redirect_pc_c
);

   logic mispredict;
   logic serial;
   logic same_rd;

   // Lane qualification, flush detection and redirect target.
   always_comb begin
      lane0_c       = 1'b0;
      lane1_c       = 1'b0;
      flush_c       = 1'b0;
      redirect_pc_c = '0;
      mispredict    = 1'b0;
      serial        = 1'b0;
      same_rd       = 1'b0;

      lane0_c    = head_busy && head_done;
      mispredict = (head_op == OP_BR) && (head_rd[0] != head_taken);
      flush_c    = lane0_c && (mispredict || (head_op == OP_JALR));

      if (head_op == OP_JALR)
         redirect_pc_c = head_target & ~32'd1;
      else if (head_taken)
         redirect_pc_c = head_pc + head_imm;
      else
         redirect_pc_c = head_pc + 32'd4;

      // Control flow and stores retire alone so redirect and store release stay simple.
      serial  = (head_op == OP_BR) || (head_op == OP_JALR) || (head_op == OP_STORE);
      same_rd = has_rd(head_op) && has_rd(nxt_op) && (head_rd != '0) && (head_rd == nxt_rd);
      lane1_c = (COMMIT_W == 2) && lane0_c && nxt_busy && nxt_done && !serial && !same_rd;
   end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with N_CDB write-back ports, CDB operand bypass and 1/2-wide commit.
module rob_multi_commit
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH    = 31,
   parameter int unsigned IDW      = 5,
   parameter int unsigned N_CDB    = 2,
   parameter int unsigned COMMIT_W = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     alloc_valid,
   input  logic [OPW-1:0]           alloc_type,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic [RW-1:0]            alloc_rd,
   input  logic [XLEN-1:0]          alloc_value,
   input  logic [XLEN-1:0]          alloc_imm,
   input  logic                     alloc_done,
   output logic                     full,
   output logic [IDW-1:0]           tail_id,
   input  logic [IDW-1:0]           q_id_1,
   input  logic [IDW-1:0]           q_id_2,
   output logic                     q_pend_1,
   output logic                     q_pend_2,
   output logic [XLEN-1:0]          q_val_1,
   output logic [XLEN-1:0]          q_val_2,
   input  logic [N_CDB-1:0]         cdb_valid,
   input  logic [N_CDB*IDW-1:0]     cdb_id,
   input  logic [N_CDB*XLEN-1:0]    cdb_value,
   output logic [COMMIT_W-1:0]      commit_valid,
   output logic [COMMIT_W-1:0]      commit_has_rd,
   output logic [COMMIT_W*IDW-1:0]  commit_id,
   output logic [COMMIT_W*RW-1:0]   commit_rd,
   output logic [COMMIT_W*XLEN-1:0] commit_value,
   output logic                     store_head,
   output logic                     flush,
   output logic [XLEN-1:0]          redirect_pc
);

   // Slots 0 and above DEPTH are never written, so they read as idle.
   localparam int unsigned NSLOT = 2 ** IDW;

   rob_entry_t      ent [NSLOT];
   logic [IDW-1:0]  head;
   logic [IDW-1:0]  tail;
   logic [IDW-1:0]  count;
   logic [IDW-1:0]  head1;
   logic [IDW-1:0]  head2;
   logic [IDW-1:0]  lane_idx [2];
   logic            lane_v [2];
   logic [1:0]      n_commit;
   logic            flush_c;
   logic            alloc_ok;
   logic [IDW-1:0]  cdb_id_a [N_CDB];
   logic [XLEN-1:0] cdb_val_a [N_CDB];
   lookup_t         look_1;
   lookup_t         look_2;

   // Unpack the CDB buses, port 0 in the low bits.
   for (genvar p = 0; p < N_CDB; p++) begin : g_cdb
      assign cdb_id_a[p]  = cdb_id[p*IDW +: IDW];
      assign cdb_val_a[p] = cdb_value[p*XLEN +: XLEN];
   end

   assign head1       = IDW'(id_inc(32'(head), DEPTH));
   assign head2       = IDW'(id_inc(32'(head1), DEPTH));
   assign lane_idx[0] = head;
   assign lane_idx[1] = head1;
   assign full        = (32'(count) == DEPTH);
   assign tail_id     = tail;
   assign alloc_ok    = alloc_valid && !full;
   assign store_head  = ent[head].busy && (ent[head].op == OP_STORE) && !ent[head].done;
   assign flush       = flush_c;
   assign n_commit    = {1'b0, lane_v[0]} + {1'b0, lane_v[1]};

   rob_commit_sel #(
      .COMMIT_W (COMMIT_W)
   ) u_sel (
      .head_busy     (ent[head].busy),
      .head_done     (ent[head].done),
      .head_op       (ent[head].op),
      .head_rd       (ent[head].rd),
      .head_pc       (ent[head].pc),
      .head_imm      (ent[head].imm),
      .head_target   (ent[head].target),
      .head_taken    (ent[head].value[0]),
      .nxt_busy      (ent[head1].busy),
      .nxt_done      (ent[head1].done),
      .nxt_op        (ent[head1].op),
      .nxt_rd        (ent[head1].rd),
      .lane0_c       (lane_v[0]),
      .lane1_c       (lane_v[1]),
      .flush_c       (flush_c),
      .redirect_pc_c (redirect_pc)
   );

   // Commit lane outputs straight from the head entries.
   for (genvar l = 0; l < COMMIT_W; l++) begin : g_lane
      assign commit_valid[l]              = lane_v[l];
      assign commit_has_rd[l]             = has_rd(ent[lane_idx[l]].op);
      assign commit_id[l*IDW +: IDW]      = lane_idx[l];
      assign commit_rd[l*RW +: RW]        = ent[lane_idx[l]].rd;
      assign commit_value[l*XLEN +: XLEN] = ent[lane_idx[l]].value;
   end

   // Operand lookup; a JALR result on the CDB is its target, so bypass keeps the link value.
   function automatic lookup_t lookup(input logic [IDW-1:0] id);
      lookup_t r;
      r = '0;
      if (ent[id].busy) begin
         if (ent[id].done) begin
            r.val = ent[id].value;
         end else begin
            r.pend = 1'b1;
            for (int p = 0; p < N_CDB; p++) begin
               if (cdb_valid[p] && (cdb_id_a[p] == id)) begin
                  r.pend = 1'b0;
                  r.val  = (ent[id].op == OP_JALR) ? ent[id].value : cdb_val_a[p];
               end
            end
         end
      end
      return r;
   endfunction

   // Two independent operand lookup ports.
   always_comb begin
      look_1 = lookup(q_id_1);
      look_2 = lookup(q_id_2);
   end

   assign q_pend_1 = look_1.pend;
   assign q_val_1  = look_1.val;
   assign q_pend_2 = look_2.pend;
   assign q_val_2  = look_2.val;

   // Entry storage and ring pointers; a flush returns everything to the reset state.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ent   <= '{default: '0};
         head  <= IDW'(1);
         tail  <= IDW'(1);
         count <= '0;
      end else if (rdy_in) begin
         if (flush_c) begin
            ent   <= '{default: '0};
            head  <= IDW'(1);
            tail  <= IDW'(1);
            count <= '0;
         end else begin
            for (int p = 0; p < N_CDB; p++) begin
               if (cdb_valid[p] && ent[cdb_id_a[p]].busy) begin
                  ent[cdb_id_a[p]].done <= 1'b1;
                  if (ent[cdb_id_a[p]].op == OP_JALR)
                     ent[cdb_id_a[p]].target <= cdb_val_a[p];
                  else
                     ent[cdb_id_a[p]].value <= cdb_val_a[p];
               end
            end
            for (int l = 0; l < 2; l++) begin
               if (lane_v[l]) begin
                  ent[lane_idx[l]].busy <= 1'b0;
                  ent[lane_idx[l]].done <= 1'b0;
               end
            end
            if (alloc_ok) begin
               ent[tail] <= rob_entry_t'{busy: 1'b1, done: alloc_done, op: alloc_type,
                                         rd: alloc_rd, pc: alloc_pc, value: alloc_value,
                                         imm: alloc_imm, target: '0};
               tail      <= IDW'(id_inc(32'(tail), DEPTH));
            end
            case (n_commit)
               2'd1:    head <= head1;
               2'd2:    head <= head2;
               default: head <= head;
            endcase
            count <= count + IDW'(alloc_ok) - IDW'(n_commit);
         end
      end
   end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomised and directed bench for rob_multi_commit against an in-order queue model.
module tb_rob_multi_commit;
   import rob_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned IDW      = 3;
   localparam int unsigned N_CDB    = 2;
   localparam int unsigned COMMIT_W = 2;

   logic                     clk_in = 1'b0;
   logic                     rst_in = 1'b0;
   logic                     rdy_in;
   logic                     alloc_valid;
   logic [6:0]               alloc_type;
   logic [31:0]              alloc_pc;
   logic [4:0]               alloc_rd;
   logic [31:0]              alloc_value;
   logic [31:0]              alloc_imm;
   logic                     alloc_done;
   logic                     full;
   logic [IDW-1:0]           tail_id;
   logic [IDW-1:0]           q_id_1;
   logic [IDW-1:0]           q_id_2;
   logic                     q_pend_1;
   logic                     q_pend_2;
   logic [31:0]              q_val_1;
   logic [31:0]              q_val_2;
   logic [N_CDB-1:0]         cdb_valid;
   logic [N_CDB*IDW-1:0]     cdb_id;
   logic [N_CDB*32-1:0]      cdb_value;
   logic [COMMIT_W-1:0]      commit_valid;
   logic [COMMIT_W-1:0]      commit_has_rd;
   logic [COMMIT_W*IDW-1:0]  commit_id;
   logic [COMMIT_W*5-1:0]    commit_rd;
   logic [COMMIT_W*32-1:0]   commit_value;
   logic                     store_head;
   logic                     flush;
   logic [31:0]              redirect_pc;

   rob_multi_commit #(
      .DEPTH (DEPTH), .IDW (IDW), .N_CDB (N_CDB), .COMMIT_W (COMMIT_W)
   ) dut (
      .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in),
      .alloc_valid (alloc_valid), .alloc_type (alloc_type), .alloc_pc (alloc_pc),
      .alloc_rd (alloc_rd), .alloc_value (alloc_value), .alloc_imm (alloc_imm),
      .alloc_done (alloc_done), .full (full), .tail_id (tail_id),
      .q_id_1 (q_id_1), .q_id_2 (q_id_2), .q_pend_1 (q_pend_1), .q_pend_2 (q_pend_2),
      .q_val_1 (q_val_1), .q_val_2 (q_val_2),
      .cdb_valid (cdb_valid), .cdb_id (cdb_id), .cdb_value (cdb_value),
      .commit_valid (commit_valid), .commit_has_rd (commit_has_rd), .commit_id (commit_id),
      .commit_rd (commit_rd), .commit_value (commit_value),
      .store_head (store_head), .flush (flush), .redirect_pc (redirect_pc)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: program-order queue of live instructions with their IDs.
   typedef struct {
      int          id;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] value;
      logic [31:0] imm;
      logic [31:0] target;
      bit          done;
   } m_ent_t;

   m_ent_t      mq[$];
   int          m_tail = 1;
   int          exp_n;
   bit          exp_flush;
   logic [31:0] exp_redir;

   function automatic bit m_has_rd(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                        7'b1100111, 7'b0010111, 7'b0110111};
   endfunction

   function automatic void exp_lookup(input int id, output bit pend, output logic [31:0] val);
      pend = 1'b0;
      val  = '0;
      if (id == 0) return;
      foreach (mq[i]) begin
         if (mq[i].id == id) begin
            if (mq[i].done) begin
               val = mq[i].value;
            end else begin
               pend = 1'b1;
               for (int p = 0; p < N_CDB; p++) begin
                  if (cdb_valid[p] && (int'(cdb_id[p*IDW +: IDW]) == id)) begin
                     pend = 1'b0;
                     val  = (mq[i].op == OP_JALR) ? mq[i].value : cdb_value[p*32 +: 32];
                  end
               end
            end
         end
      end
   endfunction

   function automatic void model_commit();
      exp_n     = 0;
      exp_flush = 1'b0;
      exp_redir = '0;
      if (mq.size() > 0 && mq[0].done) begin
         exp_n = 1;
         if (mq[0].op == OP_JALR) begin
            exp_flush = 1'b1;
            exp_redir = mq[0].target & 32'hFFFF_FFFE;
         end else if (mq[0].op == OP_BR && mq[0].rd[0] != mq[0].value[0]) begin
            exp_flush = 1'b1;
            exp_redir = mq[0].pc + (mq[0].value[0] ? mq[0].imm : 32'd4);
         end
         if (mq.size() > 1 && mq[1].done &&
             !(mq[0].op inside {OP_BR, OP_JALR, OP_STORE}) &&
             !(m_has_rd(mq[0].op) && m_has_rd(mq[1].op) && mq[0].rd != 0 && mq[0].rd == mq[1].rd))
            exp_n = 2;
      end
   endfunction

   task automatic model_check();
      bit          p;
      logic [31:0] v;
      model_commit();
      check("full", 64'(full), 64'(mq.size() == DEPTH));
      check("tail_id", 64'(tail_id), 64'(m_tail));
      check("commit_valid", 64'(commit_valid), (exp_n == 2) ? 64'd3 : 64'(exp_n));
      for (int l = 0; l < exp_n; l++) begin
         check("commit_id", 64'(commit_id[l*IDW +: IDW]), 64'(mq[l].id));
         check("commit_rd", 64'(commit_rd[l*5 +: 5]), 64'(mq[l].rd));
         check("commit_value", 64'(commit_value[l*32 +: 32]), 64'(mq[l].value));
         check("commit_has_rd", 64'(commit_has_rd[l]), 64'(m_has_rd(mq[l].op)));
      end
      check("flush", 64'(flush), 64'(exp_flush));
      if (exp_flush) check("redirect_pc", 64'(redirect_pc), 64'(exp_redir));
      check("store_head", 64'(store_head),
            64'(mq.size() > 0 && mq[0].op == OP_STORE && !mq[0].done));
      exp_lookup(int'(q_id_1), p, v);
      check("q_pend_1", 64'(q_pend_1), 64'(p));
      if (!p) check("q_val_1", 64'(q_val_1), 64'(v));
      exp_lookup(int'(q_id_2), p, v);
      check("q_pend_2", 64'(q_pend_2), 64'(p));
      if (!p) check("q_val_2", 64'(q_val_2), 64'(v));
   endtask

   task automatic model_update();
      bit     was_full;
      m_ent_t e;
      if (!rdy_in) return;
      if (exp_flush) begin
         mq.delete();
         m_tail = 1;
         return;
      end
      was_full = (mq.size() == DEPTH);
      for (int p = 0; p < N_CDB; p++) begin
         if (cdb_valid[p]) begin
            foreach (mq[i]) begin
               if (mq[i].id == int'(cdb_id[p*IDW +: IDW])) begin
                  mq[i].done = 1'b1;
                  if (mq[i].op == OP_JALR) mq[i].target = cdb_value[p*32 +: 32];
                  else                     mq[i].value  = cdb_value[p*32 +: 32];
               end
            end
         end
      end
      repeat (exp_n) void'(mq.pop_front());
      if (alloc_valid && !was_full) begin
         e.id = m_tail; e.op = alloc_type; e.rd = alloc_rd; e.pc = alloc_pc;
         e.value = alloc_value; e.imm = alloc_imm; e.target = '0; e.done = alloc_done;
         mq.push_back(e);
         m_tail = (m_tail == DEPTH) ? 1 : m_tail + 1;
      end
   endtask

   task automatic idle();
      rdy_in      = 1'b1;
      alloc_valid = 1'b0;
      alloc_type  = OP_OP;
      alloc_pc    = '0;
      alloc_rd    = '0;
      alloc_value = '0;
      alloc_imm   = '0;
      alloc_done  = 1'b0;
      q_id_1      = '0;
      q_id_2      = '0;
      cdb_valid   = '0;
      cdb_id      = '0;
      cdb_value   = '0;
   endtask

   task automatic do_alloc(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] value, input logic [31:0] imm, input logic done);
      alloc_valid = 1'b1; alloc_type = op; alloc_rd = rd; alloc_pc = pc;
      alloc_value = value; alloc_imm = imm; alloc_done = done;
   endtask

   task automatic set_cdb(input int port, input int id, input logic [31:0] val);
      cdb_valid[port]          = 1'b1;
      cdb_id[port*IDW +: IDW]  = IDW'(id);
      cdb_value[port*32 +: 32] = val;
   endtask

   // Inputs are set just after a falling edge; check, clock once, advance the model.
   task automatic step();
      #1;
      model_check();
      @(posedge clk_in);
      model_update();
      @(negedge clk_in);
      idle();
      #1;
   endtask

   task automatic random_cycle();
      int r;
      idle();
      rdy_in      = ($urandom_range(0, 9) != 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 31);
      if      (r == 0) alloc_type = OP_BR;
      else if (r == 1) alloc_type = OP_JALR;
      else if (r < 5)  alloc_type = OP_STORE;
      else if (r < 7)  alloc_type = OP_LUI;
      else if (r < 8)  alloc_type = OP_JAL;
      else if (r < 11) alloc_type = OP_LOAD;
      else if (r < 21) alloc_type = OP_OP;
      else             alloc_type = OP_OPIMM;
      alloc_rd    = 5'($urandom_range(0, 7));
      alloc_pc    = $urandom & 32'hFFFF_FFFC;
      alloc_value = $urandom;
      alloc_imm   = $urandom;
      alloc_done  = (alloc_type == OP_LUI) || (alloc_type == OP_JAL);
      for (int p = 0; p < N_CDB; p++) begin
         if ($urandom_range(0, 1) == 1) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
               set_cdb(p, mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
            else
               set_cdb(p, $urandom_range(0, 7), $urandom);
         end
      end
      q_id_1 = IDW'($urandom_range(0, 7));
      q_id_2 = IDW'($urandom_range(0, 7));
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      idle();
      q_id_1 = IDW'(2);
      #12;
      check("rst_full", 64'(full), 64'd0);
      check("rst_tail_id", 64'(tail_id), 64'd1);
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_store_head", 64'(store_head), 64'd0);
      check("rst_q_pend_1", 64'(q_pend_1), 64'd0);
      check("rst_q_val_1", 64'(q_val_1), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      idle();
      #1;

      // Fill, overflow attempt, wrap of the tail.
      for (int i = 0; i < 4; i++) begin
         do_alloc(OP_OP, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'h0, 32'h0, 1'b0);
         step();
      end
      check("fill_full", 64'(full), 64'd1);
      check("fill_tail_id", 64'(tail_id), 64'd1);
      do_alloc(OP_OP, 5'd9, 32'h2000, 32'h0, 32'h0, 1'b0);
      step();
      check("ovf_tail_id", 64'(tail_id), 64'd1);
      set_cdb(0, 1, 32'h11);
      step();
      check("wrap_commit_valid", 64'(commit_valid), 64'd1);
      check("wrap_commit_id", 64'(commit_id[IDW-1:0]), 64'd1);
      check("wrap_full_hold", 64'(full), 64'd1);
      step();
      check("wrap_full_clr", 64'(full), 64'd0);
      do_alloc(OP_OP, 5'd5, 32'h3000, 32'h0, 32'h0, 1'b0);
      step();
      check("wrap_tail_id", 64'(tail_id), 64'd2);
      check("wrap_full", 64'(full), 64'd1);
      set_cdb(1, 2, 32'h22);
      step();
      step();

      // Asynchronous reset between clock edges with live entries.
      q_id_1 = IDW'(3);
      #1;
      check("pre_rst_pend", 64'(q_pend_1), 64'd1);
      rst_in = 1'b0;
      #1;
      check("arst_full", 64'(full), 64'd0);
      check("arst_tail_id", 64'(tail_id), 64'd1);
      check("arst_commit_valid", 64'(commit_valid), 64'd0);
      check("arst_flush", 64'(flush), 64'd0);
      check("arst_q_pend_1", 64'(q_pend_1), 64'd0);
      check("arst_q_val_1", 64'(q_val_1), 64'd0);
      mq.delete();
      m_tail = 1;
      @(negedge clk_in);
      rst_in = 1'b1;
      idle();
      #1;

      // Bypass, then dual commit.
      do_alloc(OP_OP, 5'd5, 32'h100, 32'h0, 32'h0, 1'b0); step();
      do_alloc(OP_OP, 5'd6, 32'h104, 32'h0, 32'h0, 1'b0); step();
      do_alloc(OP_OP, 5'd7, 32'h108, 32'h0, 32'h0, 1'b0); step();
      q_id_1 = IDW'(3);
      set_cdb(1, 3, 32'hDEAD);
      #1;
      check("bypass_pend", 64'(q_pend_1), 64'd0);
      check("bypass_val", 64'(q_val_1), 64'hDEAD);
      step();
      set_cdb(0, 1, 32'hA1);
      set_cdb(1, 2, 32'hA2);
      step();
      check("dual_valid", 64'(commit_valid), 64'd3);
      check("dual_ids", 64'(commit_id), 64'({3'd2, 3'd1}));
      step();
      check("dual_tail_valid", 64'(commit_valid), 64'd1);
      check("dual_tail_id", 64'(commit_id[IDW-1:0]), 64'd3);
      step();
      do_alloc(OP_OP, 5'd5, 32'h200, 32'h0, 32'h0, 1'b0); step();
      do_alloc(OP_OP, 5'd5, 32'h204, 32'h0, 32'h0, 1'b0); step();
      set_cdb(0, 4, 32'hB0);
      set_cdb(1, 1, 32'hB1);
      step();
      check("samerd_first", 64'(commit_valid), 64'd1);
      step();
      check("samerd_second", 64'(commit_valid), 64'd1);
      check("samerd_second_id", 64'(commit_id[IDW-1:0]), 64'd1);
      step();

      // Mispredicted branch with a completed younger entry behind it.
      do_alloc(OP_BR, 5'd0, 32'h100, 32'h0, 32'h40, 1'b0); step();
      do_alloc(OP_OP, 5'd8, 32'h104, 32'h0, 32'h0, 1'b0); step();
      set_cdb(0, 2, 32'h1);
      set_cdb(1, 3, 32'h77);
      step();
      check("br_flush", 64'(flush), 64'd1);
      check("br_redirect", 64'(redirect_pc), 64'h140);
      check("br_lane_valid", 64'(commit_valid), 64'd1);
      step();
      check("br_post_tail", 64'(tail_id), 64'd1);
      check("br_post_commit", 64'(commit_valid), 64'd0);

      // JALR: link value written, target low bit cleared.
      do_alloc(OP_JALR, 5'd1, 32'h200, 32'h204, 32'h0, 1'b0); step();
      set_cdb(0, 1, 32'h205);
      step();
      check("jalr_has_rd", 64'(commit_has_rd[0]), 64'd1);
      check("jalr_value", 64'(commit_value[31:0]), 64'h204);
      check("jalr_flush", 64'(flush), 64'd1);
      check("jalr_redirect", 64'(redirect_pc), 64'h204);
      step();

      // Store waits at the head until completed.
      do_alloc(OP_STORE, 5'd0, 32'h300, 32'h0, 32'h0, 1'b0); step();
      check("store_head", 64'(store_head), 64'd1);
      set_cdb(0, 1, 32'h0);
      step();
      check("store_done_head", 64'(store_head), 64'd0);
      check("store_commit", 64'(commit_valid), 64'd1);
      step();

      repeat (3000) random_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
